core_mem_arb: RTL and testbench

CORE_MEM_ARB -- requirements
Module: core_mem_arb

---
 rtl/core_mem_arb.sv | 236 +++++++++++++++++++++++
 tb/tb_core_mem_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arb.sv
// Arbitrates core instruction-read, data-read and data-write requests onto one
// memory bus: slots are latched together and issued write -> data read -> instruction read.
module core_mem_arb #(
    parameter int BUS_TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [3:0]  DATA_WSTRB,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [3:0]  BUS_WSTRB,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA,
    output logic        BUS_ERR,
    output logic [1:0]  dbg_state
);

    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_DRD  = 2'd2,
        S_IRD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          pend_wr_q, pend_wr_d;
    logic          pend_drd_q, pend_drd_d;
    logic          pend_ird_q, pend_ird_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [3:0]    wr_strb_q, wr_strb_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   drd_addr_q, drd_addr_d;
    logic [31:0]   ird_addr_q, ird_addr_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic          mem_wait_q, mem_wait_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          bus_err_q, bus_err_d;
    logic          inst_rvalid_q, inst_rvalid_d;
    logic [31:0]   inst_rdata_q, inst_rdata_d;
    logic [31:0]   inst_roaddr_q, inst_roaddr_d;
    logic          data_rvalid_q, data_rvalid_d;
    logic [31:0]   data_rdata_q, data_rdata_d;
    logic [31:0]   data_roaddr_q, data_roaddr_d;

    logic accept;
    logic tmo_hit;
    logic done;
    logic issue;

    // Bus handshake: BUS_REQ with its fields is a registered request held stable until
    // the edge that sees BUS_ACK; an ACK while BUS_REQ is low carries no meaning.
    always_comb begin
        state_d       = state_q;
        pend_wr_d     = pend_wr_q;
        pend_drd_d    = pend_drd_q;
        pend_ird_d    = pend_ird_q;
        wr_addr_d     = wr_addr_q;
        wr_strb_d     = wr_strb_q;
        wr_data_d     = wr_data_q;
        drd_addr_d    = drd_addr_q;
        ird_addr_d    = ird_addr_q;
        tmo_d         = tmo_q;
        mem_wait_d    = mem_wait_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wstrb_d   = bus_wstrb_q;
        bus_wdata_d   = bus_wdata_q;
        bus_err_d     = 1'b0;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        inst_roaddr_d = inst_roaddr_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_roaddr_d = data_roaddr_q;
        issue         = 1'b0;

        accept  = !mem_wait_q && (INST_RDEN || DATA_RDEN || DATA_WREN);
        tmo_hit = bus_req_q && !BUS_ACK && (tmo_q == TMO_LAST);
        done    = bus_req_q && (BUS_ACK || tmo_hit);

        if (bus_req_q && !BUS_ACK) begin
            tmo_d = tmo_q + CW'(1);
        end

        if (accept) begin
            pend_wr_d  = DATA_WREN;
            pend_drd_d = DATA_RDEN;
            pend_ird_d = INST_RDEN;
            wr_addr_d  = DATA_WADDR;
            wr_strb_d  = DATA_WSTRB;
            wr_data_d  = DATA_WDATA;
            drd_addr_d = DATA_RIADDR;
            ird_addr_d = INST_RIADDR;
            issue      = 1'b1;
        end else if (done) begin
            // An aborted read still answers the core, with zero data.
            bus_err_d = !BUS_ACK;
            case (state_q)
                S_DRD: begin
                    data_rvalid_d = 1'b1;
                    data_rdata_d  = BUS_ACK ? BUS_RDATA : 32'h0;
                    data_roaddr_d = bus_addr_q;
                end
                S_IRD: begin
                    inst_rvalid_d = 1'b1;
                    inst_rdata_d  = BUS_ACK ? BUS_RDATA : 32'h0;
                    inst_roaddr_d = bus_addr_q;
                end
                default: ;
            endcase
            issue = 1'b1;
        end

        if (issue) begin
            tmo_d       = '0;
            bus_req_d   = 1'b1;
            mem_wait_d  = 1'b1;
            bus_we_d    = 1'b0;
            bus_wstrb_d = 4'hF;
            bus_wdata_d = 32'h0;
            if (pend_wr_d) begin
                state_d     = S_WR;
                pend_wr_d   = 1'b0;
                bus_we_d    = 1'b1;
                bus_addr_d  = wr_addr_d;
                bus_wstrb_d = wr_strb_d;
                bus_wdata_d = wr_data_d;
            end else if (pend_drd_d) begin
                state_d    = S_DRD;
                pend_drd_d = 1'b0;
                bus_addr_d = drd_addr_d;
            end else if (pend_ird_d) begin
                state_d    = S_IRD;
                pend_ird_d = 1'b0;
                bus_addr_d = ird_addr_d;
            end else begin
                state_d    = S_IDLE;
                bus_req_d  = 1'b0;
                mem_wait_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            pend_wr_q     <= 1'b0;
            pend_drd_q    <= 1'b0;
            pend_ird_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_strb_q     <= '0;
            wr_data_q     <= '0;
            drd_addr_q    <= '0;
            ird_addr_q    <= '0;
            tmo_q         <= '0;
            mem_wait_q    <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wstrb_q   <= '0;
            bus_wdata_q   <= '0;
            bus_err_q     <= 1'b0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            inst_roaddr_q <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
            data_roaddr_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_wr_q     <= pend_wr_d;
            pend_drd_q    <= pend_drd_d;
            pend_ird_q    <= pend_ird_d;
            wr_addr_q     <= wr_addr_d;
            wr_strb_q     <= wr_strb_d;
            wr_data_q     <= wr_data_d;
            drd_addr_q    <= drd_addr_d;
            ird_addr_q    <= ird_addr_d;
            tmo_q         <= tmo_d;
            mem_wait_q    <= mem_wait_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_err_q     <= bus_err_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            inst_roaddr_q <= inst_roaddr_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            data_roaddr_q <= data_roaddr_d;
        end
    end

    assign MEM_WAIT    = mem_wait_q;
    assign BUS_REQ     = bus_req_q;
    assign BUS_WE      = bus_we_q;
    assign BUS_ADDR    = bus_addr_q;
    assign BUS_WSTRB   = bus_wstrb_q;
    assign BUS_WDATA   = bus_wdata_q;
    assign BUS_ERR     = bus_err_q;
    assign INST_RVALID = inst_rvalid_q;
    assign INST_RDATA  = inst_rdata_q;
    assign INST_ROADDR = inst_roaddr_q;
    assign DATA_RVALID = data_rvalid_q;
    assign DATA_RDATA  = data_rdata_q;
    assign DATA_ROADDR = data_roaddr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_core_mem_arb.sv
// Bench for core_mem_arb: vector table plus hand sequences for timeout and reset,
// with a bus responder/monitor checking transactions and responses against queues.
module tb_core_mem_arb;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_WSTRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        BUS_ERR;
    logic [1:0]  dbg_state;

    core_mem_arb #(.BUS_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
        .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB), .DATA_WADDR(DATA_WADDR),
        .DATA_WDATA(DATA_WDATA), .MEM_WAIT(MEM_WAIT),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WSTRB(BUS_WSTRB),
        .BUS_WDATA(BUS_WDATA), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA),
        .BUS_ERR(BUS_ERR), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          wren;
        bit          drden;
        bit          irden;
        logic [31:0] waddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] daddr;
        logic [31:0] iaddr;
        int          ack_delay;
        bit          noise;
        int          exp_wait;
        bit          exp_last_rvalid;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [68:0] exp_bus_q[$];
    logic [63:0] exp_inst_q[$];
    logic [63:0] exp_data_q[$];
    bit resp_en = 1'b1;
    bit late_ack = 1'b0;
    int ack_delay = 0;
    int err_pulses = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic vec_t mk(input bit w, input bit d, input bit i,
                                input logic [31:0] wa, input logic [3:0] ws,
                                input logic [31:0] wd, input logic [31:0] da,
                                input logic [31:0] ia, input int dly, input bit nz,
                                input int ew, input bit elr);
        vec_t v;
        v.wren = w; v.drden = d; v.irden = i;
        v.waddr = wa; v.wstrb = ws; v.wdata = wd;
        v.daddr = da; v.iaddr = ia;
        v.ack_delay = dly; v.noise = nz;
        v.exp_wait = ew; v.exp_last_rvalid = elr;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=none", name, what);
    endtask

    task automatic clear_req();
        INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    endtask

    task automatic drive_noise();
        INST_RDEN   = 1'($urandom_range(0, 1));
        DATA_RDEN   = 1'($urandom_range(0, 1));
        DATA_WREN   = 1'($urandom_range(0, 1));
        INST_RIADDR = 32'hF000_0000 | $urandom_range(0, 255);
        DATA_RIADDR = 32'hF100_0000 | $urandom_range(0, 255);
        DATA_WADDR  = 32'hF200_0000 | $urandom_range(0, 255);
        DATA_WSTRB  = 4'($urandom_range(1, 15));
        DATA_WDATA  = $urandom();
    endtask

    // Bus responder and response monitor, all at the falling edge.
    initial begin
        logic [68:0] cur;
        logic [68:0] held;
        int wait_cnt;
        wait_cnt = 0;
        held = '0;
        BUS_ACK = 1'b0;
        BUS_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (INST_RVALID) begin
                if (exp_inst_q.size() == 0) flag("inst_unexpected", "rvalid");
                else check("inst_resp", {INST_ROADDR, INST_RDATA}, exp_inst_q.pop_front());
            end
            if (DATA_RVALID) begin
                if (exp_data_q.size() == 0) flag("data_unexpected", "rvalid");
                else check("data_resp", {DATA_ROADDR, DATA_RDATA}, exp_data_q.pop_front());
            end
            if (BUS_ERR) err_pulses++;
            cur = {BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WE ? BUS_WDATA : 32'h0};
            if (late_ack) begin
                BUS_ACK = 1'b1;
                BUS_RDATA = 32'hBAD0_BAD0;
            end else if (RST && BUS_REQ && resp_en) begin
                if (wait_cnt == 0) held = {BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WDATA};
                else check("bus_stable", {BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WDATA}, held);
                if (wait_cnt >= ack_delay) begin
                    BUS_ACK = 1'b1;
                    BUS_RDATA = BUS_WE ? $urandom() : mem_val(BUS_ADDR);
                    if (exp_bus_q.size() == 0) flag("bus_unexpected", "transaction");
                    else check("bus_txn", cur, exp_bus_q.pop_front());
                    wait_cnt = 0;
                end else begin
                    BUS_ACK = 1'b0;
                    BUS_RDATA = $urandom();
                    wait_cnt++;
                end
            end else begin
                BUS_ACK = 1'b0;
                BUS_RDATA = $urandom();
                wait_cnt = 0;
            end
        end
    end

    task automatic count_wait(input bit noise, output int cnt);
        int guard;
        cnt = 0;
        guard = 0;
        while (MEM_WAIT === 1'b1 && guard < 300) begin
            cnt++;
            guard++;
            if (noise) drive_noise();
            else clear_req();
            @(negedge CLK);
        end
        clear_req();
        if (guard >= 300) flag("mem_wait_stuck", "high");
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cnt;
        ack_delay   = v.ack_delay;
        DATA_WREN   = v.wren;  DATA_WADDR  = v.waddr;
        DATA_WSTRB  = v.wstrb; DATA_WDATA  = v.wdata;
        DATA_RDEN   = v.drden; DATA_RIADDR = v.daddr;
        INST_RDEN   = v.irden; INST_RIADDR = v.iaddr;
        if (v.wren) exp_bus_q.push_back({1'b1, v.waddr, v.wstrb, v.wdata});
        if (v.drden) begin
            exp_bus_q.push_back({1'b0, v.daddr, 4'hF, 32'h0});
            exp_data_q.push_back({v.daddr, mem_val(v.daddr)});
        end
        if (v.irden) begin
            exp_bus_q.push_back({1'b0, v.iaddr, 4'hF, 32'h0});
            exp_inst_q.push_back({v.iaddr, mem_val(v.iaddr)});
        end
        @(negedge CLK);
        count_wait(v.noise, cnt);
        check({tag, "_wait_cycles"}, cnt, v.exp_wait);
        check({tag, "_last_rvalid"}, INST_RVALID | DATA_RVALID, v.exp_last_rvalid);
        repeat (2) @(negedge CLK);
        check({tag, "_bus_left"}, exp_bus_q.size(), 0);
        check({tag, "_resp_left"}, exp_inst_q.size() + exp_data_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int cnt;
        int busy;
        int n;
        clear_req();
        INST_RIADDR = '0; DATA_RIADDR = '0; DATA_WADDR = '0;
        DATA_WSTRB = '0; DATA_WDATA = '0;

        vecs[0] = mk(0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0, 32'h100, 1, 0, 2, 1);
        vecs[1] = mk(1, 1, 1, 32'h2000, 4'b0011, 32'hDEAD_BEEF, 32'h2000, 32'h104, 0, 0, 3, 1);
        vecs[2] = mk(0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h40, 32'h0, 0, 0, 1, 1);
        vecs[3] = mk(1, 0, 0, 32'h3000, 4'b1000, 32'h1234_5678, 32'h0, 32'h0, 2, 1, 3, 0);
        vecs[4] = mk(1, 0, 1, 32'h10, 4'b1111, 32'hCAFE_F00D, 32'h0, 32'h200, 1, 1, 4, 1);
        vecs[5] = mk(0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h80, 32'h300, 3, 1, 8, 1);
        vecs[6] = mk(1, 1, 0, 32'h44, 4'b0101, 32'h0BAD_CAFE, 32'h48, 32'h0, 0, 1, 2, 1);

        #1 RST = 1'b0;
        #3;
        check("reset_ctrl", {MEM_WAIT, BUS_REQ, BUS_WE, BUS_ERR, INST_RVALID, DATA_RVALID,
                             BUS_WSTRB, dbg_state}, 0);
        check("reset_addr", {INST_ROADDR, DATA_ROADDR, BUS_ADDR}, 0);
        check("reset_data", {INST_RDATA, DATA_RDATA, BUS_WDATA}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 6; i++) begin
            v.wren = 1'($urandom_range(0, 1));
            v.drden = 1'($urandom_range(0, 1));
            v.irden = 1'($urandom_range(0, 1));
            if (!v.wren && !v.drden && !v.irden) v.irden = 1'b1;
            v.waddr = $urandom() & 32'hFFFF_FFFC;
            v.wstrb = 4'($urandom_range(1, 15));
            v.wdata = $urandom();
            v.daddr = $urandom() & 32'hFFFF_FFFC;
            v.iaddr = $urandom() & 32'hFFFF_FFFC;
            v.ack_delay = $urandom_range(0, 3);
            v.noise = 1'($urandom_range(0, 1));
            n = int'(v.wren) + int'(v.drden) + int'(v.irden);
            v.exp_wait = n * (v.ack_delay + 1);
            v.exp_last_rvalid = v.drden | v.irden;
            run_vec($sformatf("rnd%0d", i), v);
        end

        // Timeout: the bus never answers a data read.
        resp_en = 1'b0;
        err_pulses = 0;
        DATA_RDEN = 1'b1;
        DATA_RIADDR = 32'h2040;
        exp_data_q.push_back({32'h2040, 32'h0});
        @(negedge CLK);
        count_wait(1'b0, cnt);
        check("tmo_wait_cycles", cnt, TMO);
        check("tmo_bus_err", BUS_ERR, 1'b1);
        check("tmo_rvalid", DATA_RVALID, 1'b1);
        check("tmo_bus_req_low", BUS_REQ, 1'b0);
        @(negedge CLK);
        check("tmo_err_width", {BUS_ERR, 8'(err_pulses)}, {1'b0, 8'd1});
        check("tmo_resp_left", exp_data_q.size(), 0);
        resp_en = 1'b1;
        @(negedge CLK);

        // Reset while a three-slot request is waiting on the bus.
        resp_en = 1'b0;
        DATA_WREN = 1'b1; DATA_WADDR = 32'h500; DATA_WSTRB = 4'hF; DATA_WDATA = 32'h1;
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h504;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h508;
        @(negedge CLK);
        clear_req();
        @(negedge CLK);
        check("rst_pre_bus_req", BUS_REQ, 1'b1);
        #2 RST = 1'b0;
        #1;
        check("rst_async_ctrl", {MEM_WAIT, BUS_REQ, BUS_WE, BUS_ERR, INST_RVALID, DATA_RVALID,
                                 BUS_WSTRB, dbg_state}, 0);
        check("rst_async_addr", {INST_ROADDR, DATA_ROADDR, BUS_ADDR}, 0);
        check("rst_async_data", {INST_RDATA, DATA_RDATA, BUS_WDATA}, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1 late_ack = 1'b1;
        @(negedge CLK);
        #1 late_ack = 1'b0;
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (BUS_REQ || MEM_WAIT || INST_RVALID || DATA_RVALID || BUS_ERR) busy++;
        end
        check("rst_late_ack_ignored", busy, 0);
        resp_en = 1'b1;

        run_vec("post_rst", mk(0, 1, 1, 32'h0, 4'h0, 32'h0, 32'h600, 32'h604, 0, 0, 2, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
